gf2mz_unload: RTL and testbench

Result unloader for the GF(2^m)[z] multiplier datapath. After a polynomial product has been written into the packed coefficient memory (D coefficients of M bits per word), this block reads the memory back through its synchronous read port. It streams the N coefficients out one per cycle, in ascending degree, over a valid/ready interface. It is the reader counterpart of the multiplier's C-memory writer and feeds the encryption output serializer.

---
 rtl/gf2mz_pkg.sv | 29 ++
 rtl/gf2mz_word_buf.sv | 82 ++++++++
 rtl/gf2mz_unload.sv | 93 +++++++++
 tb/tb_gf2mz_unload.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gf2mz_pkg.sv
// Shared types and elaboration helpers for the GF(2^m)[z] coefficient memory readers.
package gf2mz_pkg;
  localparam int GF_N = 189;
  localparam int GF_M = 83;
  localparam int GF_D = 5;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int words(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int aw_of(input int v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

  // MSB of slot s in a packed word; slot 0 sits at the top of the word.
  function automatic int slot_msb(input int width, input int m, input int s);
    return width - 1 - s * m;
  endfunction
endpackage

// File: rtl/gf2mz_word_buf.sv
// Shift buffer plus one-word prefetch; presents the current slot and refills
// from prefetch (or straight from the memory read port) when a word drains.
module gf2mz_word_buf
  import gf2mz_pkg::*;
#(
  parameter int M     = GF_M,
  parameter int D     = GF_D,
  parameter int WIDTH = M * D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             accept,
  input  logic             rd_arrive,
  input  logic [WIDTH-1:0] rd_data,
  output logic [M-1:0]     slot,
  output logic             sh_valid,
  output logic             pf_empty_nxt
);
  localparam int SW  = aw_of(D);
  localparam int TOP = slot_msb(WIDTH, M, 0);

  logic [WIDTH-1:0] sh_q, sh_d, pf_q, pf_d;
  logic             sh_v_d, pf_v_q, pf_v_d, need;
  logic [SW-1:0]    cnt_q, cnt_d;

  assign need         = !sh_valid || (accept && cnt_q == SW'(D - 1));
  assign slot         = sh_q[TOP -: M];
  assign pf_empty_nxt = !pf_v_d;

  always_comb begin
    sh_d   = sh_q;
    pf_d   = pf_q;
    sh_v_d = sh_valid;
    pf_v_d = pf_v_q;
    cnt_d  = cnt_q;
    if (flush) begin
      sh_v_d = 1'b0;
      pf_v_d = 1'b0;
      cnt_d  = '0;
    end else if (need) begin
      cnt_d = '0;
      if (pf_v_q) begin
        sh_d   = pf_q;
        sh_v_d = 1'b1;
        pf_v_d = rd_arrive;
        if (rd_arrive) pf_d = rd_data;
      end else if (rd_arrive) begin
        // bypass: word lands in the shift buffer the cycle it returns
        sh_d   = rd_data;
        sh_v_d = 1'b1;
      end else begin
        sh_v_d = 1'b0;
      end
    end else begin
      if (accept) begin
        sh_d  = sh_q << M;
        cnt_d = cnt_q + 1'b1;
      end
      if (rd_arrive) begin
        pf_d   = rd_data;
        pf_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      pf_q     <= '0;
      sh_valid <= 1'b0;
      pf_v_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sh_q     <= sh_d;
      pf_q     <= pf_d;
      sh_valid <= sh_v_d;
      pf_v_q   <= pf_v_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/gf2mz_unload.sv
// Streams N packed GF(2^m) coefficients out of the C memory in ascending degree
// over valid/ready, keeping at most one read in flight.
module gf2mz_unload
  import gf2mz_pkg::*;
#(
  parameter int N     = GF_N,
  parameter int M     = GF_M,
  parameter int D     = GF_D,
  parameter int WIDTH = M * D,
  parameter int DEPTH = words(N, D),
  parameter int AW    = aw_of(DEPTH),
  parameter int IW    = aw_of(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic [M-1:0]     coef_data,
  output logic [IW-1:0]    coef_idx,
  output logic             coef_last
);
  localparam logic [AW:0]   NWORDS = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);

  state_t      state;
  logic        rd_arrive, hs, final_hs, sh_valid, pf_empty_nxt, issue;
  logic [AW:0] word_cnt;
  logic [M-1:0] slot;

  gf2mz_word_buf #(.M(M), .D(D), .WIDTH(WIDTH)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush        (final_hs),
    .accept       (hs),
    .rd_arrive    (rd_arrive),
    .rd_data      (mem_rd_data),
    .slot         (slot),
    .sh_valid     (sh_valid),
    .pf_empty_nxt (pf_empty_nxt)
  );

  assign busy       = (state != IDLE);
  assign coef_valid = sh_valid;
  assign coef_data  = sh_valid ? slot : '0;
  assign coef_last  = sh_valid && (coef_idx == LAST_I);
  assign hs         = coef_valid && coef_ready;
  assign final_hs   = hs && (coef_idx == LAST_I);

  // mem_en is registered, so decide one cycle ahead: the prefetch must be empty
  // next cycle and nothing may arrive then (mem_en now would arrive then).
  assign issue = busy && !final_hs && !mem_en && pf_empty_nxt &&
                 (word_cnt < NWORDS) && (state == STREAM || rd_arrive);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      word_cnt  <= '0;
      coef_idx  <= '0;
      rd_arrive <= 1'b0;
    end else begin
      done      <= final_hs;
      rd_arrive <= mem_en;
      mem_en    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= FILL;
          mem_en   <= 1'b1;
          mem_addr <= '0;
          word_cnt <= {{AW{1'b0}}, 1'b1};
          coef_idx <= '0;
        end
        FILL:    if (rd_arrive) state <= STREAM;
        STREAM:  if (final_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (issue) begin
        mem_en   <= 1'b1;
        mem_addr <= word_cnt[AW-1:0];
        word_cnt <= word_cnt + 1'b1;
      end
      if (hs && !final_hs) coef_idx <= coef_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_gf2mz_unload.sv
// Random-ready bench for gf2mz_unload against a coefficient-list scoreboard.
module tb_gf2mz_unload;
  localparam int N = 189, M = 83, D = 5, WIDTH = M * D, DEPTH = 38, AW = 6, IW = 8;
  localparam int LIMIT = 4 * N + 50;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, coef_ready = 1'b0;
  logic busy, done, mem_en, coef_valid, coef_last;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic [M-1:0]     coef_data;
  logic [IW-1:0]    coef_idx;

  logic [WIDTH-1:0] mem [0:63];
  logic [M-1:0]     expv [0:N-1];
  int n_vec = 0, n_err = 0;

  // small instance: N=7, M=8, D=2 -> DEPTH 4, one valid slot in last word
  logic s_start = 1'b0, s_busy, s_done, s_mem_en, s_valid, s_last;
  logic [1:0]  s_addr;
  logic [15:0] s_rd;
  logic [7:0]  s_data;
  logic [2:0]  s_idx;
  logic [15:0] smem [0:3];

  always #5 clk = ~clk;

  gf2mz_unload dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_idx(coef_idx), .coef_last(coef_last)
  );

  gf2mz_unload #(.N(7), .M(8), .D(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .mem_en(s_mem_en), .mem_addr(s_addr), .mem_rd_data(s_rd),
    .coef_valid(s_valid), .coef_ready(1'b1), .coef_data(s_data),
    .coef_idx(s_idx), .coef_last(s_last)
  );

  always @(posedge clk) if (mem_en) mem_rd_data <= mem[mem_addr];
  always @(posedge clk) if (s_mem_en) s_rd <= smem[s_addr];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy",  128'(busy), 0);
    chk("rst_done",  128'(done), 0);
    chk("rst_memen", 128'(mem_en), 0);
    chk("rst_addr",  128'(mem_addr), 0);
    chk("rst_valid", 128'(coef_valid), 0);
    chk("rst_data",  128'(coef_data), 0);
    chk("rst_idx",   128'(coef_idx), 0);
    chk("rst_last",  128'(coef_last), 0);
  endtask

  // coefficient i -> word i/D, slot i%D counted from the top; pad slots all ones
  task automatic fill(input bit rnd);
    for (int i = 0; i < N; i++)
      expv[i] = rnd ? M'({$urandom, $urandom, $urandom}) : M'(i + 1);
    for (int w = 0; w < 64; w++) mem[w] = '1;
    for (int i = 0; i < N; i++) mem[i / D][WIDTH - 1 - (i % D) * M -: M] = expv[i];
  endtask

  // Entered and left at a negedge; start is raised in the entry cycle (cycle 0).
  task automatic unload(input int pct, input int rst_k, input bit poke);
    int k, stalls, pulses;
    bit prev_stall, prev_mem, fin;
    logic [M-1:0] pd;
    logic [IW-1:0] pi;
    logic pl;
    k = 0; stalls = 0; pulses = 0; prev_stall = 0; prev_mem = 0; fin = 0;
    pd = '0; pi = '0; pl = 0;
    start = 1'b1;
    coef_ready = (int'($urandom_range(99)) < pct);
    for (int cyc = 1; cyc < LIMIT; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      chk("done", 128'(done), 128'(fin));
      if (fin) begin
        chk("busy_end", 128'(busy), 0);
        chk("valid_end", 128'(coef_valid), 0);
        chk("reads", 128'(pulses), 128'(DEPTH));
        return;
      end
      if (cyc == 1) begin
        chk("busy_c1", 128'(busy), 1);
        chk("memen_c1", 128'(mem_en), 1);
      end
      if (mem_en) begin
        chk("rd_addr", 128'(mem_addr), 128'(pulses));
        chk("rd_b2b", 128'(prev_mem), 0);
        pulses++;
      end
      prev_mem = mem_en;
      if (prev_stall) begin
        chk("hold_valid", 128'(coef_valid), 1);
        chk("hold_data", 128'(coef_data), 128'(pd));
        chk("hold_idx", 128'(coef_idx), 128'(pi));
        chk("hold_last", 128'(coef_last), 128'(pl));
      end
      coef_ready = (int'($urandom_range(99)) < pct);
      prev_stall = coef_valid && !coef_ready;
      pd = coef_data; pi = coef_idx; pl = coef_last;
      if (coef_valid && !coef_ready) stalls++;
      if (coef_valid && coef_ready) begin
        chk("data", 128'(coef_data), 128'(expv[k]));
        chk("idx", 128'(coef_idx), 128'(k));
        chk("last", 128'(coef_last), 128'(k == N - 1));
        chk("cycle", 128'(cyc), 128'(3 + k + stalls));
        if (poke && (k == 10 || k == 150)) start = 1'b1;
        if (k == rst_k) begin
          rst = 1'b1;
          #1 chk_zero();
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        k++;
        if (k == N) fin = 1;
      end
    end
    chk("timeout", 0, 1);
  endtask

  task automatic small_run();
    int k, pulses;
    k = 0; pulses = 0;
    for (int i = 0; i < 4; i++) smem[i] = {8'(2 * i + 1), (i == 3) ? 8'hFF : 8'(2 * i + 2)};
    s_start = 1'b1;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (cyc == 1) chk("s_busy", 128'(s_busy), 1);
      if (s_mem_en) begin
        chk("s_addr", 128'(s_addr), 128'(pulses));
        pulses++;
      end
      if (s_valid) begin
        chk("s_data", 128'(s_data), 128'(k + 1));
        chk("s_idx", 128'(s_idx), 128'(k));
        chk("s_last", 128'(s_last), 128'(k == 6));
        chk("s_cycle", 128'(cyc), 128'(3 + k));
        k++;
      end
      if (s_done) begin
        chk("s_count", 128'(k), 7);
        chk("s_donecyc", 128'(cyc), 10);
        chk("s_reads", 128'(pulses), 4);
        return;
      end
    end
    chk("s_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero();
    rst = 1'b0;
    @(negedge clk);
    fill(0);
    unload(100, -1, 0);   // in-order values 1..N, no stalls
    unload(100, -1, 1);   // restart in done cycle; start pokes while busy
    fill(1);
    unload(50, -1, 0);    // random data, random ready
    unload(100, 100, 0);  // reset at handshake of coefficient 100
    unload(50, -1, 0);    // clean restart after the abort
    small_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
